// File: rtl/oram_functions_pkg.sv
// Shared ORAM storage types: packed tuple/bucket layout, path command and path-server FSM states.
// Used by oram_path_server (optional ORAM_RD_CLEAR_EN build lives in the top file).
package oram_functions_pkg;

  localparam int ORAM_K = 3;

  typedef struct packed {
    logic        empty_n;
    logic [15:0] b_number;
    logic [15:0] leaf;
    logic [31:0] data;
  } memory_tuple_p;

  typedef memory_tuple_p [ORAM_K-1:0] memory_bucket_p;

  localparam int TUPLE_W  = $bits(memory_tuple_p);
  localparam int BUCKET_W = $bits(memory_bucket_p);

  typedef enum logic {READ_PATH = 1'b0, WRITE_PATH = 1'b1} path_cmd_e;

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_RD_ISSUE, S_RD_DATA, S_WR_DATA
  } path_state_e;

endpackage

// File: rtl/oram_path_server_if.sv
// Client/server bus of the ORAM path server: request, read-bucket and write-bucket channels.
// Each channel transfers on a rising clk edge where its valid and ready are both high; a source
// never waits for ready before raising valid and holds its payload stable until the transfer.
interface oram_path_server_if #(
  parameter int TREE_DEPTH = 14,
  parameter int BUCKET_W   = 195
) ();
  localparam int LVL_W = $clog2(TREE_DEPTH);

  logic                  init_done;
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [TREE_DEPTH-2:0] req_pos;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [BUCKET_W-1:0]   rd_bucket;
  logic [LVL_W-1:0]      rd_level;
  logic                  rd_last;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [BUCKET_W-1:0]   wr_bucket;

  modport master (
    input  init_done, req_ready, rd_valid, rd_bucket, rd_level, rd_last, wr_ready,
    output req_valid, req_write, req_pos, rd_ready, wr_valid, wr_bucket
  );

  modport slave (
    output init_done, req_ready, rd_valid, rd_bucket, rd_level, rd_last, wr_ready,
    input  req_valid, req_write, req_pos, rd_ready, wr_valid, wr_bucket
  );
endinterface

// File: rtl/oram_bucket_ram.sv
// Simple dual-port bucket store: one write port, one read port whose q only updates when re=1.
module oram_bucket_ram #(
  parameter int DEPTH = 16383,
  parameter int AW    = 14,
  parameter int DW    = 195
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] q
);
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re) q <= mem[raddr];
  end
endmodule

// File: rtl/oram_path_server.sv
// ORAM bucket-tree responder: clears the tree after reset, then serves READ_PATH/WRITE_PATH requests.
// Define ORAM_RD_CLEAR_EN for destructive reads (each read beat also zeroes its bucket).
module oram_path_server
  import oram_functions_pkg::*;
#(
  parameter int TREE_DEPTH = 14,
  parameter int K          = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  oram_path_server_if.slave  bus,
  output path_state_e        dbg_state
);
  localparam int NUM_NODES = (1 << TREE_DEPTH) - 1;
  localparam int BKT_W     = K * TUPLE_W;
  localparam int LVL_W     = $clog2(TREE_DEPTH);
  localparam logic [TREE_DEPTH-1:0] LAST_IDX = TREE_DEPTH'(NUM_NODES - 1);
  localparam logic [LVL_W-1:0]      LAST_LVL = LVL_W'(TREE_DEPTH - 1);

  path_state_e           state, state_n;
  logic [TREE_DEPTH-1:0] init_idx, node;
  logic [TREE_DEPTH-2:0] pos_q;
  logic [LVL_W-1:0]      level;
  logic                  init_done_q;
  logic                  accept, advance, last_lvl;
  logic                  ram_we, ram_re;
  logic [TREE_DEPTH-1:0] ram_waddr, ram_raddr;
  logic [BKT_W-1:0]      ram_wdata, ram_q;

  assign last_lvl  = (level == LAST_LVL);
  assign ram_raddr = node - TREE_DEPTH'(1);

  always_comb begin
    state_n       = state;
    accept        = 1'b0;
    advance       = 1'b0;
    ram_we        = 1'b0;
    ram_re        = 1'b0;
    ram_waddr     = node - TREE_DEPTH'(1);
    ram_wdata     = '0;
    bus.req_ready = 1'b0;
    bus.rd_valid  = 1'b0;
    bus.wr_ready  = 1'b0;
    case (state)
      S_INIT: begin
        ram_we    = 1'b1;
        ram_waddr = init_idx;
        if (init_idx == LAST_IDX) state_n = S_IDLE;
      end
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          accept  = 1'b1;
          state_n = (path_cmd_e'(bus.req_write) == WRITE_PATH) ? S_WR_DATA : S_RD_ISSUE;
        end
      end
      S_RD_ISSUE: begin
        ram_re  = 1'b1;
        state_n = S_RD_DATA;
      end
      S_RD_DATA: begin
        bus.rd_valid = 1'b1;
        if (bus.rd_ready) begin
`ifdef ORAM_RD_CLEAR_EN
          // q is already captured, so zeroing the slot now leaves this beat's data intact.
          ram_we = 1'b1;
`endif
          if (last_lvl) state_n = S_IDLE;
          else begin
            advance = 1'b1;
            state_n = S_RD_ISSUE;
          end
        end
      end
      S_WR_DATA: begin
        bus.wr_ready = 1'b1;
        if (bus.wr_valid) begin
          ram_we    = 1'b1;
          ram_wdata = bus.wr_bucket;
          if (last_lvl) state_n = S_IDLE;
          else advance = 1'b1;
        end
      end
      default: state_n = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_INIT;
      init_idx    <= '0;
      init_done_q <= 1'b0;
      node        <= TREE_DEPTH'(1);
      pos_q       <= '0;
      level       <= '0;
    end else begin
      state <= state_n;
      if (state == S_INIT) begin
        init_idx <= init_idx + TREE_DEPTH'(1);
        if (init_idx == LAST_IDX) init_done_q <= 1'b1;
      end
      if (accept) begin
        pos_q <= bus.req_pos;
        node  <= TREE_DEPTH'(1);
        level <= '0;
      end else if (advance) begin
        // Leaf bits are consumed LSB first; shifting keeps the next one at pos_q[0].
        node  <= {node[TREE_DEPTH-2:0], pos_q[0]};
        pos_q <= pos_q >> 1;
        level <= level + LVL_W'(1);
      end
    end
  end

  oram_bucket_ram #(.DEPTH(NUM_NODES), .AW(TREE_DEPTH), .DW(BKT_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (ram_raddr),
    .q     (ram_q)
  );

  assign bus.rd_bucket = ram_q;
  assign bus.rd_level  = level;
  assign bus.rd_last   = (state == S_RD_DATA) && last_lvl;
  assign bus.init_done = init_done_q;
  assign dbg_state     = state;
endmodule
